// File: rtl/fifo_stat.sv
// fifo_stat: first-word fall-through FIFO with any slot count (not limited to
// powers of two), occupancy count, almost-full/almost-empty flags and an
// optional high-water mark.
//
// Optional feature: define FIFO_PEAK_EN to build the peak_o high-water-mark
// register. Without it peak_o is tied to zero and no peak register exists.
//
// Reset is synchronous and active-high (rst_i) and has priority over flush_i
// and all transfers. The storage array is never reset or cleared.

module fifo_stat #(
  parameter int Depth             = 4,
  parameter int Width             = 32,
  parameter int AlmostFullThresh  = Depth - 1,
  parameter int AlmostEmptyThresh = 1,
  localparam int CountWidth       = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  input  logic [Width-1:0]      wr_data_i,
  output logic                  wr_ready_o,
  input  logic                  rd_ready_i,
  output logic [Width-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic [CountWidth-1:0] count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CountWidth-1:0] peak_o
);

  // Pointer width: Depth >= 2, so this is always at least one bit.
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  // Constants sized to the registers they are compared against.
  localparam logic [PtrWidth-1:0]   LastPtr  = PtrWidth'(Depth - 1);
  localparam logic [PtrWidth-1:0]   OnePtr   = PtrWidth'(1);
  localparam logic [PtrWidth-1:0]   ZeroPtr  = PtrWidth'(0);
  localparam logic [CountWidth-1:0] FullCnt  = CountWidth'(Depth);
  localparam logic [CountWidth-1:0] ZeroCnt  = CountWidth'(0);
  localparam logic [CountWidth-1:0] OneCnt   = CountWidth'(1);
  localparam logic [CountWidth-1:0] AfThresh = CountWidth'(AlmostFullThresh);
  localparam logic [CountWidth-1:0] AeThresh = CountWidth'(AlmostEmptyThresh);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter legality checks
  // ---------------------------------------------------------------------------
  if (Depth < 2) begin : g_bad_depth
    $error("fifo_stat: Depth must be >= 2");
  end
  if ((AlmostFullThresh < 1) || (AlmostFullThresh > Depth)) begin : g_bad_af
    $error("fifo_stat: AlmostFullThresh must be in 1..Depth");
  end
  if ((AlmostEmptyThresh < 0) || (AlmostEmptyThresh > Depth - 1)) begin : g_bad_ae
    $error("fifo_stat: AlmostEmptyThresh must be in 0..Depth-1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [Width-1:0]      mem_q [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q,  count_d;

  logic wr_fire_s;
  logic rd_fire_s;

  // ---------------------------------------------------------------------------
  // Handshake: a flush blocks both sides so nothing transfers in that cycle.
  // A full FIFO refuses writes even when a read completes in the same cycle.
  // ---------------------------------------------------------------------------

  // Ready/valid from the registered count, gated by flush.
  always_comb begin
    wr_ready_o = (count_q != FullCnt) && !flush_i;
    rd_valid_o = (count_q != ZeroCnt) && !flush_i;
    wr_fire_s  = wr_valid_i && wr_ready_o;
    rd_fire_s  = rd_valid_o && rd_ready_i;
  end

  // Fall-through head: the word at the read pointer is always presented.
  always_comb begin
    rd_data_o = mem_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for pointers and occupancy
  // ---------------------------------------------------------------------------

  // Write pointer advances on a completed write, wrapping at Depth-1.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      wr_ptr_d = ZeroPtr;
    end else if (wr_fire_s) begin
      if (wr_ptr_q == LastPtr) begin
        wr_ptr_d = ZeroPtr;
      end else begin
        wr_ptr_d = wr_ptr_q + OnePtr;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Read pointer advances on a completed read, wrapping at Depth-1.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = ZeroPtr;
    end else if (rd_fire_s) begin
      if (rd_ptr_q == LastPtr) begin
        rd_ptr_d = ZeroPtr;
      end else begin
        rd_ptr_d = rd_ptr_q + OnePtr;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Occupancy: +1 on write only, -1 on read only, unchanged otherwise.
  // The handshake gating keeps the result inside 0..Depth.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = ZeroCnt;
    end else begin
      case ({wr_fire_s, rd_fire_s})
        2'b10:   count_d = count_q + OneCnt;
        2'b01:   count_d = count_q - OneCnt;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Pointer and count registers with synchronous reset priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= ZeroPtr;
      rd_ptr_q <= ZeroPtr;
      count_q  <= ZeroCnt;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array: written on completed writes only, never reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire_s && !rst_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs, derived from the count register only
  // ---------------------------------------------------------------------------

  // Flags and count have no combinational path from any input.
  always_comb begin
    count_o        = count_q;
    almost_full_o  = (count_q >= AfThresh);
    almost_empty_o = (count_q <= AeThresh);
  end

  // ---------------------------------------------------------------------------
  // Optional high-water mark
  // ---------------------------------------------------------------------------
`ifdef FIFO_PEAK_EN
  logic [CountWidth-1:0] peak_q, peak_d;

  // Peak follows the count whenever the count rises above it; flush clears it.
  always_comb begin
    peak_d = peak_q;
    if (flush_i) begin
      peak_d = ZeroCnt;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_q <= ZeroCnt;
    end else begin
      peak_q <= peak_d;
    end
  end

  // Drive the peak output from its register.
  always_comb begin
    peak_o = peak_q;
  end
`else
  // Feature not built: the high-water mark reads as zero.
  always_comb begin
    peak_o = ZeroCnt;
  end
`endif

endmodule

// File: tb/tb_fifo_stat.sv
// tb_fifo_stat: directed self-checking bench for fifo_stat
// (Depth=5, Width=8, AlmostFullThresh=4, AlmostEmptyThresh=1).
// Peak expectations follow whether FIFO_PEAK_EN is defined for the build.

module tb_fifo_stat;

  localparam int Depth = 5;
  localparam int Width = 8;
  localparam int CW    = $clog2(Depth + 1);

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             wr_valid_i = 1'b0;
  logic [Width-1:0] wr_data_i = 8'h00;
  logic             wr_ready_o;
  logic             rd_ready_i = 1'b0;
  logic [Width-1:0] rd_data_o;
  logic             rd_valid_o;
  logic [CW-1:0]    count_o;
  logic             almost_full_o;
  logic             almost_empty_o;
  logic [CW-1:0]    peak_o;

  int checks = 0;
  int errors = 0;

`ifdef FIFO_PEAK_EN
  localparam bit PeakEn = 1'b1;
`else
  localparam bit PeakEn = 1'b0;
`endif

  fifo_stat #(
    .Depth(Depth), .Width(Width), .AlmostFullThresh(4), .AlmostEmptyThresh(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .count_o(count_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .peak_o(peak_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and move 1 time unit past it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0; wr_valid_i = 1'b0; rd_ready_i = 1'b0; wr_data_i = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0; settle();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready_o); end
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid_o); end
    checks++; if (almost_empty_o !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b want 1", almost_empty_o); end
    checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b want 0", almost_full_o); end
    checks++; if (peak_o !== 3'd0) begin errors++; $display("FAIL reset_peak got %0d want 0", peak_o); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_data [5];
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
    exp_data[3] = 8'h44; exp_data[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      wr_valid_i = 1'b1; wr_data_i = exp_data[i]; settle();
      if (i == 0) begin
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL no_bypass_rd_valid got %b want 0", rd_valid_o); end
      end
      tick();
      if (i == 0) begin
        checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL first_word_visible got %b want 1", rd_valid_o); end
      end
      if (i == 2) begin
        checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL af_after_3 got %b want 0", almost_full_o); end
      end
      if (i == 3) begin
        checks++; if (almost_full_o !== 1'b1) begin errors++; $display("FAIL af_after_4 got %b want 1", almost_full_o); end
        checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL wr_ready_after_4 got %b want 1", wr_ready_o); end
      end
    end
    checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL wr_ready_full got %b want 0", wr_ready_o); end
    checks++; if (count_o !== 3'd5) begin errors++; $display("FAIL count_full got %0d want 5", count_o); end
    wr_valid_i = 1'b0; rd_ready_i = 1'b1; settle();
    for (int i = 0; i < 5; i++) begin
      checks++; if ((rd_valid_o !== 1'b1) || (rd_data_o !== exp_data[i]))
        begin errors++; $display("FAIL drain_data[%0d] got %b/%h want 1/%h", i, rd_valid_o, rd_data_o, exp_data[i]); end
      tick();
    end
    rd_ready_i = 1'b0; settle();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL drain_count got %0d want 0", count_o); end
    checks++; if (almost_empty_o !== 1'b1) begin errors++; $display("FAIL drain_almost_empty got %b want 1", almost_empty_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] wdata;
    logic [7:0] rdata;
    wdata = 8'h60; rdata = 8'h60;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        wr_valid_i = 1'b1; wr_data_i = wdata; tick(); wdata = wdata + 8'h01;
      end
      wr_valid_i = 1'b0; rd_ready_i = 1'b1; settle();
      for (int i = 0; i < 3; i++) begin
        checks++; if ((rd_valid_o !== 1'b1) || (rd_data_o !== rdata))
          begin errors++; $display("FAIL wrap_data r%0d i%0d got %b/%h want 1/%h", r, i, rd_valid_o, rd_data_o, rdata); end
        tick(); rdata = rdata + 8'h01;
      end
      rd_ready_i = 1'b0;
    end
    settle();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL wrap_count got %0d want 0", count_o); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 5; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 8'hA0 + 8'(i); tick();
    end
    wr_valid_i = 1'b1; wr_data_i = 8'hEE; rd_ready_i = 1'b1; settle();
    checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL full_rw_wr_ready got %b want 0", wr_ready_o); end
    checks++; if (rd_data_o !== 8'hA0) begin errors++; $display("FAIL full_rw_head got %h want a0", rd_data_o); end
    tick();
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_rw_count got %0d want 4", count_o); end
    rd_ready_i = 1'b0; tick();
    checks++; if (count_o !== 3'd5) begin errors++; $display("FAIL full_rw_retry_count got %0d want 5", count_o); end
    wr_valid_i = 1'b0; rd_ready_i = 1'b1; settle();
    for (int i = 1; i < 6; i++) begin
      logic [7:0] e;
      e = (i == 5) ? 8'hEE : (8'hA0 + 8'(i));
      checks++; if ((rd_valid_o !== 1'b1) || (rd_data_o !== e))
        begin errors++; $display("FAIL full_rw_drain[%0d] got %b/%h want 1/%h", i, rd_valid_o, rd_data_o, e); end
      tick();
    end
    rd_ready_i = 1'b0; settle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 8'hB0 + 8'(i); tick();
    end
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count_o); end
    flush_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 8'hCC; rd_ready_i = 1'b1; settle();
    checks++; if ((wr_ready_o !== 1'b0) || (rd_valid_o !== 1'b0))
      begin errors++; $display("FAIL flush_handshake got %b/%b want 0/0", wr_ready_o, rd_valid_o); end
    tick();
    idle_inputs(); settle();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count_o); end
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL flush_rd_valid got %b want 0", rd_valid_o); end
    checks++; if (peak_o !== 3'd0) begin errors++; $display("FAIL flush_peak got %0d want 0", peak_o); end
    wr_valid_i = 1'b1; wr_data_i = 8'hD0; tick(); wr_valid_i = 1'b0; settle();
    checks++; if ((rd_valid_o !== 1'b1) || (rd_data_o !== 8'hD0))
      begin errors++; $display("FAIL flush_next_word got %b/%h want 1/d0", rd_valid_o, rd_data_o); end
    rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0; settle();
    checks++; if ((rd_valid_o !== 1'b0) || (count_o !== 3'd0))
      begin errors++; $display("FAIL flush_after_read got %b/%0d want 0/0", rd_valid_o, count_o); end
  endtask

  task automatic test_peak();
    flush_i = 1'b1; tick(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 8'h70 + 8'(i); tick();
    end
    wr_valid_i = 1'b0; rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rd_ready_i = 1'b0; settle();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL peak_drain_count got %0d want 0", count_o); end
    checks++; if (peak_o !== (PeakEn ? 3'd4 : 3'd0))
      begin errors++; $display("FAIL peak_value got %0d want %0d", peak_o, PeakEn ? 4 : 0); end
    flush_i = 1'b1; tick(); flush_i = 1'b0; settle();
    checks++; if (peak_o !== 3'd0) begin errors++; $display("FAIL peak_after_flush got %0d want 0", peak_o); end
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < 2; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 8'h90 + 8'(i); tick();
    end
    rst_i = 1'b1; flush_i = 1'b1; wr_valid_i = 1'b1; rd_ready_i = 1'b1; tick();
    rst_i = 1'b0; idle_inputs(); settle();
    checks++; if ((count_o !== 3'd0) || (rd_valid_o !== 1'b0) || (peak_o !== 3'd0))
      begin errors++; $display("FAIL midop_reset got %0d/%b/%0d want 0/0/0", count_o, rd_valid_o, peak_o); end
    checks++; if ((wr_ready_o !== 1'b1) || (almost_empty_o !== 1'b1))
      begin errors++; $display("FAIL midop_reset_flags got %b/%b want 1/1", wr_ready_o, almost_empty_o); end
  endtask

  initial begin
    tick();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_rw();
    test_flush();
    test_peak();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
